// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-segment stall/refresh generation, multi-cycle
// MDU occupancy tracking, and discard of the instruction beat orphaned by a flush.
module pipe_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic exc_flush,
    input  logic data_wait,
    input  logic ex_mdu_start,
    input  logic ex_mdu_div,
    input  logic id_load_use,
    input  logic inst_wait,
    input  logic inst_data_ok,
    output logic if_stall,
    output logic id_stall,
    output logic ex_stall,
    output logic wb_stall,
    output logic id_refresh,
    output logic ex_refresh,
    output logic wb_refresh,
    output logic inst_discard,
    output logic mdu_busy,
    output logic mdu_done
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MDU   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] mdu_last;

    assign mdu_last = ex_mdu_div ? DIV_LAST : MUL_LAST;

    // State and occupancy counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and combinational hazard outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        if_stall     = 1'b0;
        id_stall     = 1'b0;
        ex_stall     = 1'b0;
        wb_stall     = 1'b0;
        id_refresh   = 1'b0;
        ex_refresh   = 1'b0;
        wb_refresh   = 1'b0;
        inst_discard = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;

        if (reset) begin
            id_refresh = 1'b1;
            ex_refresh = 1'b1;
            wb_refresh = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
        end else if (exc_flush) begin
            id_refresh = 1'b1;
            ex_refresh = 1'b1;
            wb_refresh = 1'b1;
            cnt_d      = '0;
            if (state_q == FLUSH) begin
                // Still waiting for the orphaned beat of the earlier flush
                inst_discard = 1'b1;
                if_stall     = 1'b1;
                state_d      = FLUSH;
            end else begin
                inst_discard = inst_wait & inst_data_ok;
                state_d      = (inst_wait && !inst_data_ok) ? FLUSH : RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (data_wait) begin
                        if_stall   = 1'b1;
                        id_stall   = 1'b1;
                        ex_stall   = 1'b1;
                        wb_refresh = 1'b1;
                    end else if (ex_mdu_start) begin
                        mdu_busy   = 1'b1;
                        if_stall   = 1'b1;
                        id_stall   = 1'b1;
                        ex_stall   = 1'b1;
                        wb_refresh = 1'b1;
                        cnt_d      = CNT_W'(1);
                        state_d    = MDU;
                    end else if (id_load_use) begin
                        if_stall   = 1'b1;
                        id_stall   = 1'b1;
                        ex_refresh = 1'b1;
                    end else if (inst_wait) begin
                        if_stall   = 1'b1;
                        id_refresh = 1'b1;
                    end
                end
                MDU: begin
                    mdu_busy = 1'b1;
                    if (cnt_q < mdu_last) begin
                        if_stall   = 1'b1;
                        id_stall   = 1'b1;
                        ex_stall   = 1'b1;
                        wb_refresh = 1'b1;
                        cnt_d      = cnt_q + CNT_W'(1);
                    end else begin
                        mdu_done = 1'b1;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
                FLUSH: begin
                    inst_discard = 1'b1;
                    if_stall     = 1'b1;
                    id_refresh   = 1'b1;
                    if (inst_data_ok) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one input vector per cycle, hand-computed
// output vectors compared mid-cycle (outputs are combinational).
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic exc_flush = 1'b0, data_wait = 1'b0, ex_mdu_start = 1'b0, ex_mdu_div = 1'b0;
    logic id_load_use = 1'b0, inst_wait = 1'b0, inst_data_ok = 1'b0;
    logic if_stall, id_stall, ex_stall, wb_stall;
    logic id_refresh, ex_refresh, wb_refresh;
    logic inst_discard, mdu_busy, mdu_done;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.MUL_LAT(4), .DIV_LAT(33)) dut (
        .clk          (clk),
        .reset        (reset),
        .exc_flush    (exc_flush),
        .data_wait    (data_wait),
        .ex_mdu_start (ex_mdu_start),
        .ex_mdu_div   (ex_mdu_div),
        .id_load_use  (id_load_use),
        .inst_wait    (inst_wait),
        .inst_data_ok (inst_data_ok),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .ex_stall     (ex_stall),
        .wb_stall     (wb_stall),
        .id_refresh   (id_refresh),
        .ex_refresh   (ex_refresh),
        .wb_refresh   (wb_refresh),
        .inst_discard (inst_discard),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done)
    );

    always #5 clk = ~clk;

    // Output vector: {if_st,id_st,ex_st,wb_st,id_ref,ex_ref,wb_ref,discard,busy,done}
    logic [9:0] outs;
    assign outs = {if_stall, id_stall, ex_stall, wb_stall, id_refresh, ex_refresh,
                   wb_refresh, inst_discard, mdu_busy, mdu_done};

    // Input vector: {exc,dw,start,div,lu,iw,ok}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_EXC  = 7'b1000000;
    localparam logic [6:0] I_DW   = 7'b0100000;
    localparam logic [6:0] I_ST   = 7'b0010000;
    localparam logic [6:0] I_DIV  = 7'b0001000;
    localparam logic [6:0] I_LU   = 7'b0000100;
    localparam logic [6:0] I_IW   = 7'b0000010;
    localparam logic [6:0] I_OK   = 7'b0000001;

    localparam logic [9:0] O_IDLE  = 10'b0000000000;
    localparam logic [9:0] O_REF   = 10'b0000111000;
    localparam logic [9:0] O_REFDS = 10'b0000111100;
    localparam logic [9:0] O_MDU   = 10'b1110001010;
    localparam logic [9:0] O_DONE  = 10'b0000000011;
    localparam logic [9:0] O_DW    = 10'b1110001000;
    localparam logic [9:0] O_LU    = 10'b1100010000;
    localparam logic [9:0] O_IW    = 10'b1000100000;
    localparam logic [9:0] O_FL    = 10'b1000100100;
    localparam logic [9:0] M_ALL   = 10'b1111111111;
    localparam logic [9:0] M_NOBSY = 10'b1111111101;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs and check the resulting outputs
    task automatic cyc(input string tag, input logic rst, input logic [6:0] in,
                       input logic [9:0] exp, input logic [9:0] mask);
        @(negedge clk);
        reset = rst;
        {exc_flush, data_wait, ex_mdu_start, ex_mdu_div, id_load_use, inst_wait, inst_data_ok} = in;
        #1;
        check(tag, outs & mask, exp & mask);
    endtask

    initial begin
        // Reset dominates every input
        cyc("reset_all_in", 1'b1, 7'b1111111, O_REF, M_ALL);
        cyc("reset_quiet",  1'b1, I_NONE,     O_REF, M_ALL);
        cyc("idle",         1'b0, I_NONE,     O_IDLE, M_ALL);

        // Multiply: 4 cycles of occupancy
        cyc("mul_c0", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mul_c1", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mul_c2", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mul_c3_done", 1'b0, I_ST, O_DONE, M_ALL);
        cyc("mul_after", 1'b0, I_NONE, O_IDLE, M_ALL);

        // Divide: done exactly on cycle 32
        cyc("div_c0", 1'b0, I_ST | I_DIV, O_MDU, M_ALL);
        for (int i = 1; i < 32; i++) cyc("div_run", 1'b0, I_ST | I_DIV, O_MDU, M_ALL);
        cyc("div_c32_done", 1'b0, I_ST | I_DIV, O_DONE, M_ALL);
        cyc("div_after", 1'b0, I_NONE, O_IDLE, M_ALL);

        // Divide aborted by exception at cycle 10
        for (int i = 0; i < 10; i++) cyc("div_pre_abort", 1'b0, I_ST | I_DIV, O_MDU, M_ALL);
        cyc("div_abort", 1'b0, I_EXC | I_ST | I_DIV, O_REF, M_NOBSY);
        cyc("div_abort_run", 1'b0, I_NONE, O_IDLE, M_ALL);

        // Flush with outstanding fetch; other inputs ignored while flushing
        cyc("exc_to_flush", 1'b0, I_EXC | I_IW, O_REF, M_ALL);
        cyc("flush_c1", 1'b0, I_IW, O_FL, M_ALL);
        cyc("flush_ignore", 1'b0, I_IW | I_DW | I_LU | I_ST, O_FL, M_ALL);
        cyc("flush_beat", 1'b0, I_IW | I_OK, O_FL, M_ALL);
        cyc("flush_exit", 1'b0, I_NONE, O_IDLE, M_ALL);

        // Exception coinciding with the fetch response beat
        cyc("exc_beat", 1'b0, I_EXC | I_IW | I_OK, O_REFDS, M_ALL);
        cyc("exc_beat_run", 1'b0, I_NONE, O_IDLE, M_ALL);

        // Priority among RUN hazards
        cyc("lu_over_iw", 1'b0, I_LU | I_IW, O_LU, M_ALL);
        cyc("iw_alone", 1'b0, I_IW, O_IW, M_ALL);
        cyc("exc_over_all", 1'b0, I_EXC | I_DW | I_ST | I_LU, O_REF, M_ALL);
        cyc("dw_over_mdu", 1'b0, I_DW | I_ST, O_DW, M_ALL);
        cyc("dw_hold", 1'b0, I_DW | I_ST | I_LU, O_DW, M_ALL);
        cyc("mdu_entry", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mdu_ign_dw_lu", 1'b0, I_ST | I_DW | I_LU, O_MDU, M_ALL);
        cyc("mdu_c2", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mdu_c3_done", 1'b0, I_ST, O_DONE, M_ALL);
        cyc("mdu_post", 1'b0, I_NONE, O_IDLE, M_ALL);

        // Reset mid-divide at cnt=5
        for (int i = 0; i < 5; i++) cyc("div_pre_reset", 1'b0, I_ST | I_DIV, O_MDU, M_ALL);
        cyc("reset_mdu", 1'b1, I_ST | I_DIV, O_REF, M_ALL);
        cyc("reset_mdu_rel", 1'b0, I_NONE, O_IDLE, M_ALL);
        cyc("reset_mdu_rel2", 1'b0, I_NONE, O_IDLE, M_ALL);

        // Reset mid-flush, then a fresh multiply counts from zero
        cyc("exc_to_flush2", 1'b0, I_EXC | I_IW, O_REF, M_ALL);
        cyc("flush2_c1", 1'b0, I_IW, O_FL, M_ALL);
        cyc("reset_flush", 1'b1, I_IW, O_REF, M_ALL);
        cyc("reset_flush_rel", 1'b0, I_NONE, O_IDLE, M_ALL);
        cyc("mul2_c0", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mul2_c1", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mul2_c2", 1'b0, I_ST, O_MDU, M_ALL);
        cyc("mul2_c3_done", 1'b0, I_ST, O_DONE, M_ALL);
        cyc("mul2_after", 1'b0, I_NONE, O_IDLE, M_ALL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
